// File: rtl/gx4000_io_pkg.sv
// Shared types for the GX4000 I/O capture stage: the queued event record,
// the capture FSM states and the read-data fill value.
package gx4000_io_pkg;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        is_rd;
    } io_evt_t;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAIT_END
    } cap_state_t;

    localparam logic [7:0] IO_DATA_RD_FILL = 8'h00;

    // A genuine I/O cycle: IORQ low, not an interrupt acknowledge, exactly one of RD/WR low.
    function automatic logic io_qual(input logic iorq_n, input logic m1_n,
                                     input logic rd_n, input logic wr_n);
        return ~iorq_n & m1_n & (~wr_n ^ ~rd_n);
    endfunction

endpackage

// File: rtl/gx4000_io_capture_if.sv
// Z80 bus inputs and event-FIFO handshake of the GX4000 I/O capture stage.
// ovf_count exists only when GX4000_IO_OVF_CNT_EN is defined.
interface gx4000_io_capture_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              cpu_ce;
    logic [15:0]       cpu_addr;
    logic [7:0]        cpu_dout;
    logic              iorq_n;
    logic              rd_n;
    logic              wr_n;
    logic              m1_n;
    logic              evt_valid;
    logic              evt_ready;
    logic [15:0]       evt_addr;
    logic [7:0]        evt_data;
    logic              evt_is_rd;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;
    logic              clr_overflow;
`ifdef GX4000_IO_OVF_CNT_EN
    logic [7:0]        ovf_count;

    modport master (
        output cpu_ce, cpu_addr, cpu_dout, iorq_n, rd_n, wr_n, m1_n, evt_ready, clr_overflow,
        input  evt_valid, evt_addr, evt_data, evt_is_rd, fifo_level, overflow, ovf_count
    );
    modport slave (
        input  cpu_ce, cpu_addr, cpu_dout, iorq_n, rd_n, wr_n, m1_n, evt_ready, clr_overflow,
        output evt_valid, evt_addr, evt_data, evt_is_rd, fifo_level, overflow, ovf_count
    );
`else
    modport master (
        output cpu_ce, cpu_addr, cpu_dout, iorq_n, rd_n, wr_n, m1_n, evt_ready, clr_overflow,
        input  evt_valid, evt_addr, evt_data, evt_is_rd, fifo_level, overflow
    );
    modport slave (
        input  cpu_ce, cpu_addr, cpu_dout, iorq_n, rd_n, wr_n, m1_n, evt_ready, clr_overflow,
        output evt_valid, evt_addr, evt_data, evt_is_rd, fifo_level, overflow
    );
`endif

endinterface

// File: rtl/gx4000_io_fifo.sv
// Synchronous event FIFO; a push while full is accepted only when a pop
// happens in the same cycle.
module gx4000_io_fifo
    import gx4000_io_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk_sys,
    input  logic                              reset,
    input  logic                              i_push,
    input  io_evt_t                           i_push_data,
    input  logic                              i_pop,
    output io_evt_t                           o_head,
    output logic                              o_full,
    output logic                              o_empty,
    output logic [$clog2(FIFO_DEPTH):0]       o_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    io_evt_t          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_full    = (r_level == LVL_W'(FIFO_DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    // Storage is cleared too so the head reads as all-zero straight out of reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level <= r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop_ok);
        end
    end

endmodule

// File: rtl/gx4000_io_capture.sv
// GX4000 I/O capture: one FIFO event per confirmed Z80 IORQ read/write cycle.
// Optional ovf_count output enabled by defining GX4000_IO_OVF_CNT_EN.
module gx4000_io_capture
    import gx4000_io_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CONFIRM    = 2
) (
    input  logic                clk_sys,
    input  logic                reset,
    gx4000_io_capture_if.slave  bus
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    cap_state_t       r_state;
    logic [2:0]       r_cnt;
    logic             r_push;
    io_evt_t          r_evt;
    logic             r_overflow;
    logic             w_qual;
    logic             w_is_rd;
    logic [7:0]       w_data_now;
    io_evt_t          w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop_ok;
    logic             w_drop;
    logic [LVL_W-1:0] w_level;

    assign w_qual     = io_qual(bus.iorq_n, bus.m1_n, bus.rd_n, bus.wr_n);
    assign w_is_rd    = ~bus.rd_n;
    assign w_data_now = w_is_rd ? IO_DATA_RD_FILL : bus.cpu_dout;

    // Starting in WAIT_END drops any bus cycle that was already running at reset release.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= WAIT_END;
            r_cnt   <= '0;
            r_push  <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (bus.cpu_ce) begin
                unique case (r_state)
                    IDLE: begin
                        if (w_qual) begin
                            r_cnt        <= 3'd1;
                            r_evt.addr   <= bus.cpu_addr;
                            r_evt.data   <= w_data_now;
                            r_evt.is_rd  <= w_is_rd;
                            if (CONFIRM == 1) begin
                                r_push  <= 1'b1;
                                r_state <= WAIT_END;
                            end else begin
                                r_state <= ARM;
                            end
                        end
                    end
                    ARM: begin
                        if (w_qual && (w_is_rd == r_evt.is_rd)) begin
                            if (r_cnt + 3'd1 == 3'(CONFIRM)) begin
                                r_evt.data <= w_data_now;
                                r_push     <= 1'b1;
                                r_state    <= WAIT_END;
                            end else begin
                                r_cnt <= r_cnt + 3'd1;
                            end
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    WAIT_END: begin
                        if (bus.iorq_n) r_state <= IDLE;
                    end
                    default: r_state <= WAIT_END;
                endcase
            end
        end
    end

    gx4000_io_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .i_push      (r_push),
        .i_push_data (r_evt),
        .i_pop       (bus.evt_ready),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level)
    );

    assign w_pop_ok = bus.evt_ready & ~w_empty;
    assign w_drop   = r_push & w_full & ~w_pop_ok;

`ifdef GX4000_IO_OVF_CNT_EN
    logic [7:0] r_ovf_count;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_ovf_count <= '0;
        end else if (w_drop) begin
            r_overflow  <= 1'b1;
            r_ovf_count <= (r_ovf_count == 8'hFF) ? 8'hFF : r_ovf_count + 8'd1;
        end else if (bus.clr_overflow) begin
            r_overflow  <= 1'b0;
            r_ovf_count <= '0;
        end
    end

    assign bus.ovf_count = r_ovf_count;
`else
    // A drop outranks a clear arriving in the same cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end
`endif

    assign bus.evt_valid  = ~w_empty;
    assign bus.evt_addr   = w_head.addr;
    assign bus.evt_data   = w_head.data;
    assign bus.evt_is_rd  = w_head.is_rd;
    assign bus.fifo_level = w_level;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_gx4000_io_capture.sv
// Self-checking bench for gx4000_io_capture: directed scenarios plus randomized
// Z80 traffic checked against an event-level reference model.
module tb_gx4000_io_capture;
    import gx4000_io_pkg::*;

    localparam int DEPTH = 4;
    localparam int CONF  = 2;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        is_rd;
    } ev_t;

    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    gx4000_io_capture_if #(.FIFO_DEPTH(DEPTH)) bus ();

    gx4000_io_capture #(
        .FIFO_DEPTH (DEPTH),
        .CONFIRM    (CONF)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: event queue, sticky flag/counter, run tracker per IORQ assertion.
    ev_t         m_q[$];
    bit          m_ovf;
    int          m_cnt;
    bit          m_done;
    int          m_run;
    bit          m_run_rd;
    logic [15:0] m_run_addr;
    bit          m_pending;
    ev_t         m_pend_ev;

    task automatic model_step();
        bit pop_ok, drop, accept, qual, rd;
        if (reset) begin
            m_q.delete();
            m_ovf = 0; m_cnt = 0; m_done = 1; m_run = 0; m_pending = 0;
            return;
        end
        pop_ok = bus.evt_ready && (m_q.size() > 0);
        drop = 0; accept = 0;
        if (m_pending) begin
            if (m_q.size() < DEPTH || pop_ok) accept = 1;
            else drop = 1;
        end
        if (pop_ok) void'(m_q.pop_front());
        if (accept) m_q.push_back(m_pend_ev);
        if (drop) begin
            m_ovf = 1;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end else if (bus.clr_overflow) begin
            m_ovf = 0; m_cnt = 0;
        end
        m_pending = 0;
        if (bus.cpu_ce) begin
            qual = !bus.iorq_n && bus.m1_n && ((!bus.wr_n) != (!bus.rd_n));
            rd   = !bus.rd_n;
            if (bus.iorq_n) begin
                m_done = 0; m_run = 0;
            end else if (!m_done) begin
                if (!qual) m_run = 0;
                else if (m_run == 0) begin
                    m_run = 1; m_run_rd = rd; m_run_addr = bus.cpu_addr;
                end else if (m_run_rd == rd) m_run++;
                else m_run = 0;
                if (m_run == CONF) begin
                    m_pending = 1;
                    m_pend_ev = '{addr: m_run_addr, data: (m_run_rd ? 8'h00 : bus.cpu_dout),
                                  is_rd: m_run_rd};
                    m_done = 1; m_run = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_step();
        #1;
    endtask

    task automatic drive(input bit ce, input bit iorq_n, input bit rd_n, input bit wr_n,
                         input bit m1_n, input logic [15:0] a, input logic [7:0] d);
        bus.cpu_ce = ce; bus.iorq_n = iorq_n; bus.rd_n = rd_n; bus.wr_n = wr_n;
        bus.m1_n = m1_n; bus.cpu_addr = a; bus.cpu_dout = d;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 1, 1, 1, 1, 16'h0000, 8'h00);
    endtask

    task automatic write_cycle(input logic [15:0] a, input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 1, 0, 1, a, d);
        idle(1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.evt_ready = 0; bus.clr_overflow = 0;
        drive(1, 1, 1, 1, 1, 16'h0000, 8'h00);
        drive(1, 1, 1, 1, 1, 16'h0000, 8'h00);
        n_cmp++; if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.evt_valid); end
        n_cmp++; if (bus.fifo_level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", bus.fifo_level); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
        n_cmp++; if (bus.evt_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", bus.evt_addr); end
        n_cmp++; if (bus.evt_data !== 8'h00 || bus.evt_is_rd !== 1'b0) begin
            n_fail++; $display("FAIL reset_data: got %h/%b want 00/0", bus.evt_data, bus.evt_is_rd); end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_out_write();
        drive(1, 0, 1, 0, 1, 16'h7F00, 8'h10);
        drive(1, 0, 1, 0, 1, 16'h7F00, 8'h10);
        n_cmp++; if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL out_latency_early: got %b want 0", bus.evt_valid); end
        drive(1, 0, 1, 0, 1, 16'h7F00, 8'h10);
        n_cmp++; if (bus.evt_valid !== 1'b1) begin n_fail++; $display("FAIL out_valid: got %b want 1", bus.evt_valid); end
        n_cmp++; if ({bus.evt_addr, bus.evt_data, bus.evt_is_rd} !== {16'h7F00, 8'h10, 1'b0}) begin
            n_fail++; $display("FAIL out_event: got %h/%h/%b want 7f00/10/0", bus.evt_addr, bus.evt_data, bus.evt_is_rd); end
        drive(1, 0, 1, 0, 1, 16'h7F00, 8'h10);
        idle(2);
        n_cmp++; if (bus.fifo_level !== LVL_W'(1)) begin n_fail++; $display("FAIL out_once: got level %0d want 1", bus.fifo_level); end
        bus.evt_ready = 1; idle(1); bus.evt_ready = 0;
        n_cmp++; if (bus.fifo_level !== '0) begin n_fail++; $display("FAIL out_pop: got level %0d want 0", bus.fifo_level); end
    endtask

    task automatic test_glitch();
        drive(1, 0, 0, 1, 1, 16'h1234, 8'hAA);
        idle(3);
        n_cmp++; if (bus.fifo_level !== '0) begin n_fail++; $display("FAIL glitch_level: got %0d want 0", bus.fifo_level); end
        n_cmp++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL glitch_state: got %0d want %0d", dut.r_state, IDLE); end
    endtask

    task automatic test_int_ack();
        for (int i = 0; i < 6; i++) drive(1, 0, 1, 1, 0, 16'h00FF, 8'h00);
        idle(3);
        n_cmp++; if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL intack_valid: got %b want 0", bus.evt_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) write_cycle(16'hBC00 + 16'(i), 8'hA0 + 8'(i), 3);
        idle(1);
        n_cmp++; if (bus.fifo_level !== LVL_W'(4)) begin n_fail++; $display("FAIL ovf_level: got %0d want 4", bus.fifo_level); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
`ifdef GX4000_IO_OVF_CNT_EN
        n_cmp++; if (bus.ovf_count !== 8'd1) begin n_fail++; $display("FAIL ovf_count: got %0d want 1", bus.ovf_count); end
`endif
        bus.evt_ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.evt_valid !== 1'b1 || bus.evt_addr !== 16'hBC00 + 16'(i) || bus.evt_data !== 8'hA0 + 8'(i)) begin
                n_fail++; $display("FAIL ovf_drain%0d: got %b/%h/%h want 1/%h/%h", i, bus.evt_valid,
                                   bus.evt_addr, bus.evt_data, 16'hBC00 + 16'(i), 8'hA0 + 8'(i));
            end
            idle(1);
        end
        bus.evt_ready = 0;
        n_cmp++; if (bus.fifo_level !== '0 || bus.overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: got level %0d ovf %b want 0/1", bus.fifo_level, bus.overflow); end
        bus.clr_overflow = 1; idle(1); bus.clr_overflow = 0;
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < 4; i++) write_cycle(16'hC000 + 16'(i), 8'h50 + 8'(i), 3);
        drive(1, 0, 1, 0, 1, 16'hC004, 8'h54);
        drive(1, 0, 1, 0, 1, 16'hC004, 8'h54);
        bus.evt_ready = 1;
        drive(1, 0, 1, 0, 1, 16'hC004, 8'h54);
        bus.evt_ready = 0;
        idle(1);
        n_cmp++; if (bus.fifo_level !== LVL_W'(4) || bus.overflow !== 1'b0) begin
            n_fail++; $display("FAIL fullpp: got level %0d ovf %b want 4/0", bus.fifo_level, bus.overflow); end
        bus.evt_ready = 1;
        for (int i = 1; i < 5; i++) begin
            n_cmp++;
            if (bus.evt_addr !== 16'hC000 + 16'(i) || bus.evt_data !== 8'h50 + 8'(i)) begin
                n_fail++; $display("FAIL fullpp_drain%0d: got %h/%h want %h/%h", i, bus.evt_addr,
                                   bus.evt_data, 16'hC000 + 16'(i), 8'h50 + 8'(i));
            end
            idle(1);
        end
        bus.evt_ready = 0;
    endtask

    task automatic test_reset_mid_arm();
        drive(1, 0, 1, 0, 1, 16'h5555, 8'h77);
        reset = 1'b1;
        drive(1, 0, 1, 0, 1, 16'h5555, 8'h77);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, 1, 16'h5555, 8'h77);
        idle(2);
        n_cmp++; if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL rstarm_none: got %b want 0", bus.evt_valid); end
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 1, 16'hF700, 8'hEE);
        idle(1);
        n_cmp++; if ({bus.evt_valid, bus.evt_addr, bus.evt_data, bus.evt_is_rd} !== {1'b1, 16'hF700, 8'h00, 1'b1}) begin
            n_fail++; $display("FAIL rstarm_in: got %b/%h/%h/%b want 1/f700/00/1", bus.evt_valid,
                               bus.evt_addr, bus.evt_data, bus.evt_is_rd); end
        bus.evt_ready = 1; idle(1); bus.evt_ready = 0;
    endtask

    task automatic test_random();
        int rem = 0, kind = 0, half = 0;
        bit in_txn = 0, ce, rd_n, wr_n, m1_n, iorq_n;
        logic [15:0] a = '0;
        reset = 1'b1; idle(1); reset = 1'b0;
        for (int t = 0; t < 1500; t++) begin
            if (rem == 0) begin
                in_txn = !in_txn;
                rem  = in_txn ? $urandom_range(1, 5) : $urandom_range(1, 2);
                half = rem / 2;
                kind = $urandom_range(0, 7);
                a    = 16'($urandom);
            end
            ce = ($urandom_range(0, 3) != 0);
            iorq_n = !in_txn; m1_n = 1; rd_n = 1; wr_n = 1;
            if (in_txn) begin
                case (kind)
                    0: m1_n = 0;
                    1: begin rd_n = 0; wr_n = 0; end
                    2: begin rd_n = (rem > half); wr_n = !rd_n; end
                    default: begin rd_n = kind[0]; wr_n = !kind[0]; end
                endcase
            end
            bus.evt_ready    = ($urandom_range(0, 3) == 0);
            bus.clr_overflow = ($urandom_range(0, 15) == 0);
            drive(ce, iorq_n, rd_n, wr_n, m1_n, a, 8'($urandom));
            if (ce) rem--;
            n_cmp++;
            if (bus.evt_valid !== (m_q.size() > 0) || bus.fifo_level !== LVL_W'(m_q.size())) begin
                n_fail++; $display("FAIL rnd_level t=%0d: got %b/%0d want %b/%0d", t, bus.evt_valid,
                                   bus.fifo_level, m_q.size() > 0, m_q.size());
            end
            n_cmp++;
            if (bus.overflow !== m_ovf) begin
                n_fail++; $display("FAIL rnd_ovf t=%0d: got %b want %b", t, bus.overflow, m_ovf);
            end
`ifdef GX4000_IO_OVF_CNT_EN
            n_cmp++;
            if (bus.ovf_count !== 8'(m_cnt)) begin
                n_fail++; $display("FAIL rnd_ovfcnt t=%0d: got %0d want %0d", t, bus.ovf_count, m_cnt);
            end
`endif
            if (m_q.size() > 0) begin
                n_cmp++;
                if ({bus.evt_addr, bus.evt_data, bus.evt_is_rd} !== {m_q[0].addr, m_q[0].data, m_q[0].is_rd}) begin
                    n_fail++; $display("FAIL rnd_head t=%0d: got %h/%h/%b want %h/%h/%b", t, bus.evt_addr,
                                       bus.evt_data, bus.evt_is_rd, m_q[0].addr, m_q[0].data, m_q[0].is_rd);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.cpu_ce = 0; bus.cpu_addr = '0; bus.cpu_dout = '0;
        bus.iorq_n = 1; bus.rd_n = 1; bus.wr_n = 1; bus.m1_n = 1;
        bus.evt_ready = 0; bus.clr_overflow = 0;
        test_reset();
        test_out_write();
        test_glitch();
        test_int_ack();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_arm();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
